// File: rtl/dcc_cmd_scheduler.sv
// DCC command scheduler: mixes priority packets with round-robin refresh of an 8-slot table.
// Optional build macro DCC_SCHED_STATS_EN enables the stat_pkt_cnt issue counter.
module dcc_cmd_scheduler #(
  parameter int PRI_DEPTH  = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        slot_we,
  input  logic [2:0]  slot_addr,
  input  logic [16:0] slot_wdata,
  input  logic        pri_valid,
  input  logic [31:0] pri_word,
  output logic        pri_ready,
  input  logic        gen_req,
  output logic [31:0] gen_word,
  output logic        gen_valid,
  output logic        req_overrun,
  output logic [15:0] stat_pkt_cnt
);

  localparam int AW = $clog2(PRI_DEPTH);
  localparam int RW = $clog2(STARVE_MAX + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(STARVE_MAX);
  localparam logic [31:0] IDLE_WORD = 32'h0D0000FF;

  typedef enum logic [1:0] {S_WAIT, S_ARB, S_EMIT} state_t;

  state_t        state, state_nxt;
  logic [16:0]   slot_tab [8];
  logic [31:0]   fifo_mem [PRI_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full, push, pop;
  logic [2:0]    rr_ptr, rr_sel;
  logic          rr_found;
  logic [RW-1:0] pri_run;
  logic [31:0]   arb_word;
  logic          arb_pri, arb_ref;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_WAIT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:  if (gen_req) state_nxt = S_ARB;
      S_ARB:   state_nxt = S_EMIT;
      S_EMIT:  state_nxt = S_WAIT;
      default: state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) slot_tab[i] <= '0;
    end else if (slot_we) begin
      slot_tab[slot_addr] <= slot_wdata;
    end
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pri_ready  = !fifo_full;
  assign push       = pri_valid && !fifo_full;
  assign pop        = (state == S_ARB) && arb_pri;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= pri_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_comb begin
    rr_found = 1'b0;
    rr_sel   = rr_ptr;
    for (int i = 0; i < 8; i++) begin
      if (!rr_found && slot_tab[rr_ptr + 3'(i)][16]) begin
        rr_found = 1'b1;
        rr_sel   = rr_ptr + 3'(i);
      end
    end
  end

  // Priority wins until the starvation limit, then a refresh is forced if any slot is live.
  always_comb begin
    arb_pri  = 1'b0;
    arb_ref  = 1'b0;
    arb_word = IDLE_WORD;
    if (!fifo_empty && (pri_run < RUN_MAX)) arb_pri = 1'b1;
    else if (rr_found)                      arb_ref = 1'b1;
    else if (!fifo_empty)                   arb_pri = 1'b1;
    if (arb_pri)
      arb_word = fifo_mem[rd_ptr[AW-1:0]];
    else if (arb_ref)
      arb_word = {8'h0D, 8'h00, slot_tab[rr_sel][7:0], slot_tab[rr_sel][15:8]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gen_word <= IDLE_WORD;
      rr_ptr   <= '0;
      pri_run  <= '0;
    end else if (state == S_ARB) begin
      gen_word <= arb_word;
      if (arb_pri) pri_run <= (pri_run == RUN_MAX) ? pri_run : pri_run + 1'b1;
      else         pri_run <= '0;
      if (arb_ref) rr_ptr <= rr_sel + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       req_overrun <= 1'b0;
    else if (gen_req && state != S_WAIT) req_overrun <= 1'b1;
  end

  assign gen_valid = (state == S_EMIT);

`ifdef DCC_SCHED_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       stat_pkt_cnt <= '0;
    else if (gen_valid) stat_pkt_cnt <= stat_pkt_cnt + 16'd1;
  end
`else
  assign stat_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_dcc_cmd_scheduler.sv
// Randomized self-checking bench for dcc_cmd_scheduler against a queue-based reference model.
// Honors DCC_SCHED_STATS_EN when the design is built with it.
module tb_dcc_cmd_scheduler;

  localparam int DEPTH  = 4;
  localparam int STARVE = 3;
  localparam logic [31:0] IDLE = 32'h0D0000FF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        slot_we = 1'b0;
  logic [2:0]  slot_addr = '0;
  logic [16:0] slot_wdata = '0;
  logic        pri_valid = 1'b0;
  logic [31:0] pri_word = '0;
  logic        gen_req = 1'b0;
  logic        pri_ready;
  logic [31:0] gen_word;
  logic        gen_valid;
  logic        req_overrun;
  logic [15:0] stat_pkt_cnt;

  int total = 0;
  int bad   = 0;

  logic [16:0] m_slot [8];
  logic [31:0] m_q [$];
  int          m_rr;
  int          m_run;
  logic        m_over;
  logic [15:0] m_stat;

  dcc_cmd_scheduler #(.PRI_DEPTH(DEPTH), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .reset_n(reset_n), .slot_we(slot_we), .slot_addr(slot_addr),
    .slot_wdata(slot_wdata), .pri_valid(pri_valid), .pri_word(pri_word),
    .pri_ready(pri_ready), .gen_req(gen_req), .gen_word(gen_word),
    .gen_valid(gen_valid), .req_overrun(req_overrun), .stat_pkt_cnt(stat_pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 8; i++) m_slot[i] = '0;
    m_q.delete();
    m_rr = 0; m_run = 0; m_over = 1'b0; m_stat = '0;
  endfunction

  // Reference arbitration: priority under the starvation limit, else next live slot, else leftover priority, else idle.
  function automatic logic [31:0] modelArb();
    int s;
    if (m_q.size() > 0 && m_run < STARVE) begin
      m_run = (m_run + 1 > STARVE) ? STARVE : m_run + 1;
      return m_q.pop_front();
    end
    for (int k = 0; k < 8; k++) begin
      s = (m_rr + k) % 8;
      if (m_slot[s][16]) begin
        m_rr = (s + 1) % 8;
        m_run = 0;
        return {8'h0D, 8'h00, m_slot[s][7:0], m_slot[s][15:8]};
      end
    end
    if (m_q.size() > 0) begin
      m_run = (m_run + 1 > STARVE) ? STARVE : m_run + 1;
      return m_q.pop_front();
    end
    m_run = 0;
    return IDLE;
  endfunction

  task automatic writeSlot(input logic [2:0] a, input logic [16:0] d);
    @(negedge clk);
    slot_we = 1'b1; slot_addr = a; slot_wdata = d;
    @(negedge clk);
    slot_we = 1'b0;
    m_slot[a] = d;
  endtask

  task automatic pushPri(input logic [31:0] w);
    @(negedge clk);
    pri_valid = 1'b1; pri_word = w;
    checkOutput("pri_ready", {31'b0, pri_ready}, {31'b0, m_q.size() < DEPTH});
    @(negedge clk);
    pri_valid = 1'b0;
    if (m_q.size() < DEPTH) m_q.push_back(w);
  endtask

  // One gen_req pulse; overlap picks what else happens during ARB: 1 extra gen_req, 2 slot write, 3 push.
  task automatic applyStimulus(input int overlap, input logic [2:0] oa, input logic [16:0] od,
                               input logic [31:0] ow, output logic [31:0] issued);
    logic [31:0] exp;
    logic        full_before;
    @(negedge clk);
    gen_req = 1'b1;
    @(negedge clk);
    gen_req = 1'b0;
    checkOutput("valid_in_arb", {31'b0, gen_valid}, 32'd0);
    full_before = (m_q.size() >= DEPTH);
    exp = modelArb();
    case (overlap)
      1: gen_req = 1'b1;
      2: begin slot_we = 1'b1; slot_addr = oa; slot_wdata = od; end
      3: begin pri_valid = 1'b1; pri_word = ow; end
      default: ;
    endcase
    @(negedge clk);
    gen_req = 1'b0; slot_we = 1'b0; pri_valid = 1'b0;
    case (overlap)
      1: m_over = 1'b1;
      2: m_slot[oa] = od;
      3: if (!full_before) m_q.push_back(ow);
      default: ;
    endcase
    checkOutput("valid_in_emit", {31'b0, gen_valid}, 32'd1);
    checkOutput("gen_word", gen_word, exp);
`ifdef DCC_SCHED_STATS_EN
    m_stat = m_stat + 16'd1;
`endif
    @(negedge clk);
    checkOutput("valid_after", {31'b0, gen_valid}, 32'd0);
    checkOutput("word_hold", gen_word, exp);
    checkOutput("overrun", {31'b0, req_overrun}, {31'b0, m_over});
    checkOutput("stat_cnt", {16'b0, stat_pkt_cnt}, {16'b0, m_stat});
    if (overlap == 1) begin
      repeat (3) begin
        @(negedge clk);
        checkOutput("no_extra_valid", {31'b0, gen_valid}, 32'd0);
      end
    end
    issued = exp;
  endtask

  task automatic checkResetState();
    checkOutput("rst_valid", {31'b0, gen_valid}, 32'd0);
    checkOutput("rst_word", gen_word, IDLE);
    checkOutput("rst_ready", {31'b0, pri_ready}, 32'd1);
    checkOutput("rst_overrun", {31'b0, req_overrun}, 32'd0);
    checkOutput("rst_stat", {16'b0, stat_pkt_cnt}, 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] p [6];
    modelReset();
    repeat (2) @(negedge clk);
    checkResetState();
    reset_n = 1'b1;

    applyStimulus(0, 3'd0, '0, '0, w);
    checkOutput("idle_const", w, 32'h0D0000FF);

    writeSlot(3'd2, {1'b1, 8'h03, 8'h3F});
    writeSlot(3'd5, {1'b1, 8'h07, 8'h80});
    applyStimulus(0, 3'd0, '0, '0, w); checkOutput("rr_1", gen_word, 32'h0D003F03);
    applyStimulus(0, 3'd0, '0, '0, w); checkOutput("rr_2", gen_word, 32'h0D008007);
    applyStimulus(0, 3'd0, '0, '0, w); checkOutput("rr_3", gen_word, 32'h0D003F03);

    writeSlot(3'd5, '0);
    for (int i = 0; i < 6; i++) p[i] = 32'h0A000000 + 32'(i * 17 + 1);
    for (int i = 0; i < 4; i++) pushPri(p[i]);
    applyStimulus(0, 3'd0, '0, '0, w); checkOutput("starve_p0", w, p[0]);
    pushPri(p[4]);
    applyStimulus(0, 3'd0, '0, '0, w); checkOutput("starve_p1", w, p[1]);
    applyStimulus(0, 3'd0, '0, '0, w); checkOutput("starve_p2", w, p[2]);
    applyStimulus(0, 3'd0, '0, '0, w); checkOutput("starve_ref", w, 32'h0D003F03);
    applyStimulus(0, 3'd0, '0, '0, w); checkOutput("starve_p3", w, p[3]);
    applyStimulus(0, 3'd0, '0, '0, w); checkOutput("starve_p4", w, p[4]);

    writeSlot(3'd2, '0);
    for (int i = 0; i < 5; i++) pushPri(32'h5A000000 + 32'(i));
    @(negedge clk);
    checkOutput("full_ready", {31'b0, pri_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 3'd0, '0, '0, w);
      checkOutput("fifo_order", w, 32'h5A000000 + 32'(i));
    end
    applyStimulus(0, 3'd0, '0, '0, w); checkOutput("dropped_gone", w, IDLE);

    applyStimulus(1, 3'd0, '0, '0, w);
    checkOutput("overrun_set", {31'b0, req_overrun}, 32'd1);

    applyStimulus(2, 3'd0, {1'b1, 8'h11, 8'h22}, '0, w); checkOutput("late_slot", w, IDLE);
    applyStimulus(0, 3'd0, '0, '0, w); checkOutput("late_slot_next", w, 32'h0D002211);
    writeSlot(3'd0, '0);
    applyStimulus(3, 3'd0, '0, 32'hCAFE0001, w); checkOutput("late_push", w, IDLE);
    applyStimulus(0, 3'd0, '0, '0, w); checkOutput("late_push_next", w, 32'hCAFE0001);

    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3)
        writeSlot(3'($urandom_range(0, 7)), 17'($urandom));
      else if (r < 6)
        pushPri($urandom);
      else
        applyStimulus((r == 9) ? int'($urandom_range(0, 3)) : 0, 3'($urandom_range(0, 7)),
                      17'($urandom), $urandom, w);
    end

    writeSlot(3'd4, {1'b1, 8'h44, 8'h55});
    pushPri(32'h12345678);
    @(negedge clk);
    gen_req = 1'b1;
    @(negedge clk);
    gen_req = 1'b0;
    reset_n = 1'b0;
    modelReset();
    @(negedge clk);
    checkResetState();
    @(negedge clk);
    checkOutput("abort_no_valid", {31'b0, gen_valid}, 32'd0);
    reset_n = 1'b1;
    applyStimulus(0, 3'd0, '0, '0, w); checkOutput("post_reset_idle", w, IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcc_cmd_scheduler.md
DCC_CMD_SCHEDULER -- requirements
Module: dcc_cmd_scheduler

Interface
REQ-001 SHALL have port clk  input  1  rising-edge system clock.
REQ-002 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port slot_we  input  1  write strobe into the refresh slot table.
REQ-004 SHALL have port slot_addr  input  3  slot index 0-7.
REQ-005 SHALL have port slot_wdata  input  17  [16]=enable, [15:8]=loco address byte, [7:0]=speed byte.
REQ-006 SHALL have port pri_valid  input  1  priority packet push request.
REQ-007 SHALL have port pri_word  input  32  priority packet in generator word format.
REQ-008 SHALL have port pri_ready  output  1  priority FIFO not full.
REQ-009 SHALL have port gen_req  input  1  one-cycle pulse from the packet generator requesting the next packet.
REQ-010 SHALL have port gen_word  output  32  selected packet: bytes [7:0],[15:8],[23:16]; byte tags [25:24],[27:26],[29:28] (00 empty, 01 valid, 11 last); [31:30]=0.
REQ-011 SHALL have port gen_valid  output  1  one-cycle strobe, gen_word is new.
REQ-012 SHALL have port req_overrun  output  1  sticky flag, gen_req arrived while busy.
REQ-013 SHALL have port stat_pkt_cnt  output  16  packets issued (see Configuration).
REQ-014 SHALL have parameter PRI_DEPTH, default 4, priority FIFO depth (power of two, >=2).
REQ-015 SHALL have parameter STARVE_MAX, default 3, max consecutive priority packets before a forced refresh.

Function
REQ-016 SHALL hold an 8-entry slot table; slot_we writes slot_wdata to slot_addr on the clock edge, visible from the next cycle.
REQ-017 SHALL push pri_word into the FIFO when pri_valid && pri_ready; pri_ready = FIFO not full; push while full is dropped, FIFO unchanged.
REQ-018 SHALL run FSM WAIT -> ARB -> EMIT -> WAIT; WAIT leaves only on gen_req; ARB and EMIT last one cycle each.
REQ-019 SHALL assert gen_valid in EMIT, exactly 2 cycles after the gen_req pulse; gen_word updates in that cycle and holds until the next EMIT.
REQ-020 SHALL arbitrate in ARB: (a) FIFO non-empty and pri_run < STARVE_MAX -> pop FIFO head; (b) else any slot enabled -> refresh; (c) else FIFO non-empty -> pop head; (d) else idle packet.
REQ-021 SHALL pick the refresh slot round-robin: first enabled slot at or after rr_ptr, wrapping 7->0; rr_ptr becomes chosen slot+1 mod 8.
REQ-022 SHALL build refresh word = {8'h0D, 8'h00, speed, address}.
REQ-023 SHALL build idle word = 32'h0D0000FF.
REQ-024 SHALL increment pri_run (saturating at STARVE_MAX) on a priority issue and clear it on a refresh or idle issue.
REQ-025 SHALL use table contents registered before the ARB edge; a same-cycle slot write affects the next arbitration only.
REQ-026 SHALL allow FIFO push and ARB pop in the same cycle; when empty at ARB, a same-cycle push is not selectable.
REQ-027 SHALL set req_overrun on gen_req in ARB or EMIT, ignore that request, and clear the flag only by reset.

Reset
REQ-028 SHALL on reset_n low: FSM=WAIT, all slots disabled and zeroed, FIFO empty, rr_ptr=0, pri_run=0, gen_valid=0, gen_word=32'h0D0000FF, pri_ready=1, req_overrun=0, stat_pkt_cnt=0.
REQ-029 SHALL, when reset asserts mid-ARB/EMIT, abort and issue nothing; the first post-reset gen_req is served normally.

Configuration
REQ-030 SHALL with DCC_SCHED_STATS_EN defined increment stat_pkt_cnt by one per gen_valid, wrapping 16'hFFFF->0.
REQ-031 SHALL without DCC_SCHED_STATS_EN tie stat_pkt_cnt to 0 and build no counter.

Verification
REQ-032 SHALL cover: reset, gen_req pulse -> gen_valid 2 cycles later with gen_word=32'h0D0000FF.
REQ-033 SHALL cover: slots 2 (addr 03, speed 3F) and 5 (addr 07, speed 80) enabled, 3 gen_reqs -> 32'h0D003F03, 32'h0D008007, 32'h0D003F03.
REQ-034 SHALL cover: slot 2 enabled, 5 priority words P0-P4 pushed, 5 gen_reqs -> P0,P1,P2,refresh slot 2,P3; P4 pending.
REQ-035 SHALL cover: 4 pushes fill FIFO -> pri_ready=0; 5th push dropped; 4 pops return the first 4 words in order.
REQ-036 SHALL cover: gen_req during ARB -> req_overrun=1, exactly one gen_valid issued.
REQ-037 SHALL cover: DCC_SCHED_STATS_EN defined with stat_pkt_cnt at 16'hFFFF, one issue -> 0; undefined -> stat_pkt_cnt always 0.
